// File: rtl/adis16209_poller_if.sv
// adis16209_poller_if: SPI engine handshake plus host byte-write request channel
interface adis16209_poller_if;
  logic spi_strobe_out;
  logic [15:0] spi_value_out;
  logic spi_strobe_in;
  logic [15:0] spi_value_in;
  logic wr_req;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  logic wr_ack;
  modport master (
    output spi_strobe_out, spi_value_out, wr_ack,
    input spi_strobe_in, spi_value_in, wr_req, wr_addr, wr_data
  );
  modport slave (
    input spi_strobe_out, spi_value_out, wr_ack,
    output spi_strobe_in, spi_value_in, wr_req, wr_addr, wr_data
  );
endinterface

// File: rtl/adis16209_poller.sv
// adis16209_poller: periodic pipelined ADIS16209 register sweep with host writes in the gaps
module adis16209_poller #(
  parameter int poll_period = 64000,
  parameter int stall_cycles = 640,
  parameter logic [5:0] addr0 = 6'h0C,
  parameter logic [5:0] addr1 = 6'h0E,
  parameter logic [5:0] addr2 = 6'h10,
  parameter logic [5:0] addr3 = 6'h0A
) (
  input logic clock,
  input logic reset,
  input logic enable,
  adis16209_poller_if.master bus,
  output logic [15:0] sample0,
  output logic [15:0] sample1,
  output logic [15:0] sample2,
  output logic [15:0] sample3,
  output logic sample_valid,
  output logic busy,
  output logic overrun
);
  localparam int pw = $clog2(poll_period);
  localparam int sw = $clog2(stall_cycles);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_XFER, STALL, DONE} state_t;
  state_t state, state_next;
  logic [pw-1:0] period_cnt;
  logic [sw-1:0] stall_cnt;
  logic [2:0] idx;
  logic [15:0] shadow [4];
  logic [5:0] addr_sel;
  logic is_write, sweep_pending, wrap, running, write_ok, start_write, start_sweep, stall_done;
  always_comb begin
    wrap = period_cnt == '0;
    running = !is_write && (state == ISSUE || state == WAIT_XFER || state == STALL);
    // the acked request is still visible for one cycle; it must not launch a second write
    write_ok = bus.wr_req && !bus.wr_ack;
    start_write = state == IDLE && enable && write_ok;
    start_sweep = state == IDLE && enable && !write_ok && sweep_pending;
    stall_done = state == STALL && stall_cnt == '0;
    addr_sel = idx == 3'd1 ? addr1 : idx == 3'd2 ? addr2 : idx == 3'd3 ? addr3 : addr0;
    bus.spi_strobe_out = state == ISSUE;
    busy = state != IDLE;
    state_next = state;
    case (state)
      IDLE: state_next = (start_write || start_sweep) ? ISSUE : IDLE;
      ISSUE: state_next = WAIT_XFER;
      WAIT_XFER: state_next = bus.spi_strobe_in ? STALL : WAIT_XFER;
      STALL: state_next = !stall_done ? STALL : is_write ? IDLE : idx <= 3'd4 ? ISSUE : DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      period_cnt <= pw'(poll_period - 1);
      stall_cnt <= '0;
      idx <= '0;
      is_write <= 1'b0;
      sweep_pending <= 1'b0;
      overrun <= 1'b0;
      bus.spi_value_out <= '0;
      bus.wr_ack <= 1'b0;
      sample_valid <= 1'b0;
      shadow <= '{default: '0};
      {sample0, sample1, sample2, sample3} <= '0;
    end else begin
      state <= state_next;
      period_cnt <= wrap ? pw'(poll_period - 1) : period_cnt - 1'b1;
      bus.wr_ack <= stall_done && is_write;
      sample_valid <= state == DONE;
      if (start_write || start_sweep) begin
        is_write <= start_write;
        bus.spi_value_out <= start_write ? {2'b10, bus.wr_addr, bus.wr_data} : {2'b00, addr0, 8'h00};
      end
      if (stall_done && !is_write && idx <= 3'd4)
        bus.spi_value_out <= {2'b00, addr_sel, 8'h00};
      // the sensor answers one frame late: response k belongs to the address of transaction k-1
      if (state == WAIT_XFER && bus.spi_strobe_in) begin
        stall_cnt <= sw'(stall_cycles - 1);
        if (!is_write) begin
          idx <= idx + 3'd1;
          if (idx != 3'd0) shadow[2'(idx - 3'd1)] <= bus.spi_value_in;
        end
      end
      if (state == STALL && !stall_done) stall_cnt <= stall_cnt - 1'b1;
      if (state == DONE) begin
        idx <= '0;
        {sample0, sample1, sample2, sample3} <= {shadow[0], shadow[1], shadow[2], shadow[3]};
      end
      if (wrap && enable && (sweep_pending || running)) overrun <= 1'b1;
      if (wrap && enable && !sweep_pending && !running) sweep_pending <= 1'b1;
      else if ((state == ISSUE && !is_write && idx == 3'd0) || state == DONE) sweep_pending <= 1'b0;
    end
  end
endmodule

// File: tb/tb_adis16209_poller.sv
// tb_adis16209_poller: directed bench with a one-frame-latency sensor model
module tb_adis16209_poller;
  localparam int period = 4096;
  localparam int stall = 640;
  logic clock = 1'b0;
  logic reset, enable;
  logic [15:0] sample0, sample1, sample2, sample3;
  logic sample_valid, busy, overrun;
  adis16209_poller_if bus();
  adis16209_poller #(.poll_period(period), .stall_cycles(stall)) dut (
    .clock(clock), .reset(reset), .enable(enable), .bus(bus),
    .sample0(sample0), .sample1(sample1), .sample2(sample2), .sample3(sample3),
    .sample_valid(sample_valid), .busy(busy), .overrun(overrun)
  );
  always #5 clock = ~clock;
  int checks = 0, errors = 0;
  int cyc, xfer_delay = 10, cnt;
  logic [5:0] prev = 6'h00;
  logic [15:0] cmd_q;
  always @(posedge clock) cyc <= reset ? 0 : cyc + 1;
  // sensor model: replies after xfer_delay clocks with 0xA000 | previous command's address
  always @(posedge clock) begin
    if (reset) begin
      cnt <= 0;
      bus.spi_strobe_in <= 1'b0;
      bus.spi_value_in <= '0;
    end else begin
      bus.spi_strobe_in <= 1'b0;
      if (bus.spi_strobe_out) begin
        cnt <= xfer_delay;
        cmd_q <= bus.spi_value_out;
      end else if (cnt == 1) begin
        cnt <= 0;
        bus.spi_strobe_in <= 1'b1;
        bus.spi_value_in <= 16'hA000 | {10'h000, prev};
        prev <= cmd_q[13:8];
      end else if (cnt > 1) cnt <= cnt - 1;
    end
  end
  int n_out = 0, n_valid = 0, n_ack = 0, out_cyc, valid_cyc, ack_cyc, last_in, min_gap = 1 << 30;
  logic have_in = 1'b0;
  logic [15:0] cmds [$];
  always @(negedge clock) begin
    if (reset) have_in = 1'b0;
    else begin
      if (bus.spi_strobe_out) begin
        n_out++;
        cmds.push_back(bus.spi_value_out);
        out_cyc = cyc;
        if (have_in && cyc - last_in < min_gap) min_gap = cyc - last_in;
      end
      if (bus.spi_strobe_in) begin
        last_in = cyc;
        have_in = 1'b1;
      end
      if (sample_valid) begin
        n_valid++;
        valid_cyc = cyc;
      end
      if (bus.wr_ack) begin
        n_ack++;
        ack_cyc = cyc;
      end
    end
  end
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask
  task automatic wait_cyc(input int x);
    while (cyc < x) step(1);
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic int count_of(input int which);
    return which == 0 ? n_out : which == 1 ? n_valid : n_ack;
  endfunction
  task automatic wait_ev(input string tag, input int which, input int target, input int limit);
    int t = 0;
    while (count_of(which) < target && t < limit) begin
      step(1);
      t++;
    end
    check(tag, 32'(count_of(which) >= target), 32'd1);
  endtask
  int nv, na, no;
  initial begin
    reset = 1'b1;
    enable = 1'b1;
    bus.wr_req = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    step(3);
    reset = 1'b0;
    check("rst_strobe_out", 32'(bus.spi_strobe_out), 0);
    check("rst_value_out", 32'(bus.spi_value_out), 0);
    check("rst_wr_ack", 32'(bus.wr_ack), 0);
    check("rst_sample_valid", 32'(sample_valid), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_samples", {sample0, sample3}, 0);
    wait_ev("first_issue_wait", 0, 1, 5000);
    check("first_issue_cyc", out_cyc, 4097);
    check("cmd0", 32'(cmds[0]), 32'h0C00);
    wait_ev("sweep1_wait", 1, 1, 4000);
    check("sweep1_latency", valid_cyc, 4097 + 5 * (xfer_delay + 642) + 1);
    check("sample0", 32'(sample0), 32'hA00C);
    check("sample1", 32'(sample1), 32'hA00E);
    check("sample2", 32'(sample2), 32'hA010);
    check("sample3", 32'(sample3), 32'hA00A);
    check("valid_count1", n_valid, 1);
    check("strobe_count1", n_out, 5);
    check("cmd1", 32'(cmds[1]), 32'h0E00);
    check("cmd2", 32'(cmds[2]), 32'h1000);
    check("cmd3", 32'(cmds[3]), 32'h0A00);
    check("cmd4_dummy", 32'(cmds[4]), 32'h0C00);
    check("stall_gap1", min_gap, 641);
    wait_cyc(8192);
    bus.wr_addr = 6'h36;
    bus.wr_data = 8'h5A;
    bus.wr_req = 1'b1;
    wait_ev("write_issue_wait", 0, 6, 100);
    check("write_cmd", 32'(cmds[5]), 32'hB65A);
    check("write_issue_cyc", out_cyc, 8193);
    wait_ev("wr_ack_wait", 2, 1, 2000);
    bus.wr_req = 1'b0;
    check("wr_ack_delay", ack_cyc - last_in, 641);
    wait_ev("sweep2_issue_wait", 0, 7, 100);
    check("sweep2_cmd0", 32'(cmds[6]), 32'h0C00);
    check("sweep2_issue_cyc", out_cyc, 8846);
    wait_ev("sweep2_wait", 1, 2, 4000);
    check("sweep2_sample1", 32'(sample1), 32'hA00E);
    check("wr_ack_count", n_ack, 1);
    check("overrun_nominal", 32'(overrun), 0);
    wait_ev("tx2_wait", 0, 14, 6000);
    step(5);
    reset = 1'b1;
    step(2);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_strobe", 32'(bus.spi_strobe_out), 0);
    nv = n_valid;
    na = n_ack;
    reset = 1'b0;
    step(3000);
    check("midrst_no_valid", n_valid, nv);
    check("midrst_no_ack", n_ack, na);
    wait_ev("post_rst_wait", 1, nv + 1, 6000);
    check("post_rst_latency", valid_cyc, 7358);
    check("post_rst_sample0", 32'(sample0), 32'hA00C);
    check("post_rst_sample3", 32'(sample3), 32'hA00A);
    wait_cyc(7400);
    enable = 1'b0;
    no = n_out;
    wait_cyc(17000);
    check("disabled_no_strobe", n_out, no);
    check("disabled_overrun", 32'(overrun), 0);
    check("disabled_busy", 32'(busy), 0);
    xfer_delay = 1000;
    enable = 1'b1;
    wait_ev("reenable_wait", 0, no + 1, 5000);
    check("reenable_cyc", out_cyc, 20481);
    wait_cyc(24600);
    check("overrun_set", 32'(overrun), 1);
    wait_ev("slow_sweep1_wait", 1, nv + 2, 10000);
    check("slow_sweep1_cyc", valid_cyc, 28692);
    wait_ev("slow_sweep2_wait", 1, nv + 3, 15000);
    check("slow_sweep2_cyc", valid_cyc, 40980);
    check("overrun_sticky", 32'(overrun), 1);
    check("slow_sample2", 32'(sample2), 32'hA010);
    check("stall_gap_all", min_gap, 641);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
